// File: rtl/instr_controller.sv
// Instruction register, field decoder and control FSM for the register-file/shifter/ALU datapath.
// Executes one instruction per start handshake: MOV imm, MOV reg, ADD, CMP, AND, MVN.
//
// state  | meaning
// WAIT   | idle / ready (w=1); IR may be loaded, s starts execution
// DECODE | classify IR, no strobes
// WIMM   | write sximm8 into Rn
// GETA   | load A from Rn
// GETB   | load B from Rm
// CALC   | load C with the ALU result
// CMPS   | load status flags only (CMP)
// WRC    | write C into Rd
module instr_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_WIMM   = 3'd2;
  localparam logic [2:0] S_GETA   = 3'd3;
  localparam logic [2:0] S_GETB   = 3'd4;
  localparam logic [2:0] S_CALC   = 3'd5;
  localparam logic [2:0] S_CMPS   = 3'd6;
  localparam logic [2:0] S_WRC    = 3'd7;

  logic [2:0]  state, state_nxt;
  logic [15:0] ir;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op;
  logic       is_mov_imm, is_mov_reg, is_mvn, is_alu2, is_cmp;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  assign is_alu2    = (opcode == 3'b101) && (op != 2'b11);
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);

  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign shift  = ir[4:3];
  assign ALUop  = (opcode == 3'b101) ? op : 2'b00;
  assign asel   = is_mov_reg || is_mvn;
  assign bsel   = 1'b0;

  // IR only changes in WAIT, so it is stable for the whole instruction
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= 16'h0000;
    end else begin
      if ((state == S_WAIT) && load)
        ir <= in;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   if (s) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_mov_imm)                state_nxt = S_WIMM;
        else if (is_mov_reg || is_mvn) state_nxt = S_GETB;
        else if (is_alu2)              state_nxt = S_GETA;
        else                           state_nxt = S_WAIT;
      end
      S_WIMM:   state_nxt = S_WAIT;
      S_GETA:   state_nxt = S_GETB;
      S_GETB:   state_nxt = is_cmp ? S_CMPS : S_CALC;
      S_CALC:   state_nxt = S_WRC;
      S_CMPS:   state_nxt = S_WAIT;
      S_WRC:    state_nxt = S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    vsel     = 4'b0000;
    readnum  = 3'd0;
    writenum = 3'd0;
    case (state)
      S_WAIT: w = 1'b1;
      S_WIMM: begin
        write    = 1'b1;
        vsel     = 4'b0100;
        writenum = rn;
      end
      S_GETA: begin
        loada   = 1'b1;
        readnum = rn;
      end
      S_GETB: begin
        loadb   = 1'b1;
        readnum = rm;
      end
      S_CALC: loadc = 1'b1;
      S_CMPS: loads = 1'b1;
      S_WRC: begin
        write    = 1'b1;
        vsel     = 4'b0001;
        writenum = rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_controller.sv
// Scoreboard bench for instr_controller: a per-instruction step-plan reference model pushes
// the expected outputs of every cycle; a negedge monitor pops and compares.
module tb_instr_controller;

  logic        clk = 1'b0;
  logic        reset_n, load, s;
  logic [15:0] in;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [3:0]  vsel;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm5, sximm8;

  instr_controller dut (
    .clk(clk), .reset_n(reset_n), .in(in), .load(load), .s(s),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .sximm5(sximm5), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic        write, loada, loadb, loadc, loads;
    logic [3:0]  vsel;
    logic [2:0]  readnum, writenum;
    logic [15:0] ir;
  } exp_t;

  exp_t        sb[$];
  exp_t        plan[$];
  logic [15:0] m_ir;
  logic        busy;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic exp_t mk(logic wv, logic wr, logic la, logic lb, logic lc, logic ls,
                              logic [3:0] vs, logic [2:0] rdn, logic [2:0] wrn, logic [15:0] irv);
    exp_t e;
    e.w = wv; e.write = wr; e.loada = la; e.loadb = lb; e.loadc = lc; e.loads = ls;
    e.vsel = vs; e.readnum = rdn; e.writenum = wrn; e.ir = irv;
    return e;
  endfunction

  // Sequence of busy-cycle strobes an instruction produces, derived from its fields
  task automatic build_plan(input logic [15:0] irv);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    opc = irv[15:13]; op = irv[12:11]; rn = irv[10:8]; rd = irv[7:5]; rm = irv[2:0];
    plan.delete();
    plan.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0000, 3'd0, 3'd0, irv));
    if (opc == 3'b110 && op == 2'b10) begin
      plan.push_back(mk(0, 1, 0, 0, 0, 0, 4'b0100, 3'd0, rn, irv));
    end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
      plan.push_back(mk(0, 0, 0, 1, 0, 0, 4'b0000, rm, 3'd0, irv));
      plan.push_back(mk(0, 0, 0, 0, 1, 0, 4'b0000, 3'd0, 3'd0, irv));
      plan.push_back(mk(0, 1, 0, 0, 0, 0, 4'b0001, 3'd0, rd, irv));
    end else if (opc == 3'b101) begin
      plan.push_back(mk(0, 0, 1, 0, 0, 0, 4'b0000, rn, 3'd0, irv));
      plan.push_back(mk(0, 0, 0, 1, 0, 0, 4'b0000, rm, 3'd0, irv));
      if (op == 2'b01) begin
        plan.push_back(mk(0, 0, 0, 0, 0, 1, 4'b0000, 3'd0, 3'd0, irv));
      end else begin
        plan.push_back(mk(0, 0, 0, 0, 1, 0, 4'b0000, 3'd0, 3'd0, irv));
        plan.push_back(mk(0, 1, 0, 0, 0, 0, 4'b0001, 3'd0, rd, irv));
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, queue the expected outputs
  task automatic step(input logic rst_v, input logic ld, input logic [15:0] din, input logic st);
    exp_t cur;
    reset_n = rst_v; load = ld; in = din; s = st;
    @(posedge clk);
    if (!rst_v) begin
      m_ir = 16'h0000;
      plan.delete();
      busy = 1'b0;
      cur = mk(1, 0, 0, 0, 0, 0, 4'b0000, 3'd0, 3'd0, m_ir);
    end else if (busy) begin
      if (plan.size() > 0) begin
        cur = plan.pop_front();
      end else begin
        busy = 1'b0;
        cur = mk(1, 0, 0, 0, 0, 0, 4'b0000, 3'd0, 3'd0, m_ir);
      end
    end else begin
      if (ld) m_ir = din;
      if (st) begin
        build_plan(m_ir);
        cur = plan.pop_front();
        busy = 1'b1;
      end else begin
        cur = mk(1, 0, 0, 0, 0, 0, 4'b0000, 3'd0, 3'd0, m_ir);
      end
    end
    sb.push_back(cur);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 16'h0000, 0);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 6))
      0: r[15:11] = 5'b110_10;
      1: r[15:11] = 5'b110_00;
      2: r[15:11] = 5'b101_00;
      3: r[15:11] = 5'b101_01;
      4: r[15:11] = 5'b101_10;
      5: r[15:11] = 5'b101_11;
      default: ;
    endcase
    return r;
  endfunction

  initial begin : monitor
    exp_t e;
    logic [16:0] act_strb, exp_strb;
    logic [37:0] act_dec, exp_dec;
    logic [2:0]  opc;
    logic [1:0]  op;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        opc = e.ir[15:13];
        op  = e.ir[12:11];
        act_strb = {w, write, loada, loadb, loadc, loads, vsel, readnum, writenum};
        exp_strb = {e.w, e.write, e.loada, e.loadb, e.loadc, e.loads, e.vsel, e.readnum, e.writenum};
        act_dec = {ALUop, asel, bsel, shift, sximm5, sximm8};
        exp_dec = {(opc == 3'b101) ? op : 2'b00,
                   (opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11),
                   1'b0, e.ir[4:3],
                   {{11{e.ir[4]}}, e.ir[4:0]}, {{8{e.ir[7]}}, e.ir[7:0]}};
        vectors++;
        if (act_strb !== exp_strb) begin
          miscompares++;
          $display("FAIL strobes t=%0t ir=%h {w,wr,la,lb,lc,ls,vsel,rd,wn} actual=%h required=%h",
                   $time, e.ir, act_strb, exp_strb);
        end
        vectors++;
        if (act_dec !== exp_dec) begin
          miscompares++;
          $display("FAIL decode t=%0t ir=%h {ALUop,asel,bsel,shift,sx5,sx8} actual=%h required=%h",
                   $time, e.ir, act_dec, exp_dec);
        end
      end
    end
  end

  initial begin : driver
    m_ir = 16'h0000;
    busy = 1'b0;
    reset_n = 1'b0; load = 1'b0; s = 1'b0; in = 16'h0000;
    step(0, 0, 16'h0000, 0);
    idle(2);
    // MOV imm
    step(1, 1, 16'hD1FE, 0);
    step(1, 0, 16'h0000, 1);
    idle(4);
    // ADD
    step(1, 1, 16'hA148, 0);
    step(1, 0, 16'h0000, 1);
    idle(6);
    // CMP, then MVN
    step(1, 1, 16'hA801, 1);
    idle(5);
    step(1, 1, 16'hB860, 1);
    idle(5);
    // MOV reg loaded and started together; a load during CALC must be ignored
    step(1, 1, 16'hC082, 1);
    step(1, 0, 16'h0000, 0);
    step(1, 1, 16'hD007, 0);
    step(1, 1, 16'hD007, 0);
    idle(3);
    // s held high: back-to-back re-execution
    for (int i = 0; i < 12; i++) step(1, 0, 16'h0000, 1);
    idle(2);
    // abort during GETB of ADD
    step(1, 1, 16'hA148, 1);
    idle(2);
    step(0, 0, 16'h0000, 0);
    idle(4);
    // illegal opcode
    step(1, 1, 16'hE000, 1);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0), rand_instr(),
           ($urandom_range(0, 2) == 0));
    idle(8);
    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_controller.md
Name: instr_controller

Overview:
- Instruction register, decoder and control FSM that drives the control inputs of the existing register-file/shifter/ALU datapath.
- Executes one instruction per start handshake: MOV immediate, MOV register with shift, ADD, CMP, AND and MVN.
- It is the producer of every datapath control strobe. Its outputs connect one-to-one to the datapath control ports of the same name.

Parameters:
- none (the datapath word width is fixed at 16)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- in  input  16  instruction word
- load  input  1  capture `in` into IR; honoured only in WAIT
- s  input  1  start execution of IR; sampled only in WAIT
- w  output  1  high only in WAIT (ready / instruction done)
- readnum  output  3  register-file read index
- writenum  output  3  register-file write index
- write  output  1  register-file write enable
- vsel  output  4  one-hot writeback select: [3]=mdata, [2]=sximm8, [1]=PC, [0]=C
- loada, loadb, loadc, loads  output  1 each  datapath register loads
- asel  output  1  1 forces Ain=0
- bsel  output  1  1 selects sximm5; always 0 (reserved for later load/store)
- shift  output  2  IR[4:3]
- ALUop  output  2  ALU operation
- sximm5  output  16  sign-extended IR[4:0]
- sximm8  output  16  sign-extended IR[7:0]

Behaviour:
- Reset is synchronous: when reset_n=0 at a clk edge, the next state is WAIT and IR=16'h0000, regardless of the current state (mid-instruction abort).
- After reset: w=1; write, loada, loadb, loadc, loads=0; readnum=writenum=0; vsel=0.
- IR field decode: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Always-on combinational outputs from IR:
  - sximm5 = {{11{IR[4]}},IR[4:0]}; sximm8 = {{8{IR[7]}},IR[7:0]}; shift = sh.
  - ALUop = op when opcode=101, else 00.
  - asel = 1 for MOV register (110/00) and MVN (101/11), else 0.
  - bsel = 0.
- Strobes (write, loada, loadb, loadc, loads, vsel, readnum, writenum) are Moore outputs of the state. They are 0 in every state except as listed below.
- States and transitions:
  - WAIT: w=1. If load=1, IR<=in. If s=1, go to DECODE. If load and s are both 1 in the same cycle, the newly loaded IR is the one executed.
  - DECODE: no strobes.
    - 110/10 (MOV imm) -> WIMM.
    - 110/00 (MOV reg) and 101/11 (MVN) -> GETB.
    - 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> GETA.
    - Any other encoding -> WAIT, no side effects.
  - WIMM: write=1, vsel=0100, writenum=Rn -> WAIT.
  - GETA: loada=1, readnum=Rn -> GETB.
  - GETB: loadb=1, readnum=Rm -> CMPS if the instruction is CMP, else CALC.
  - CALC: loadc=1 -> WRC.
  - CMPS: loads=1, loadc=0 -> WAIT (no register write).
  - WRC: write=1, vsel=0001, writenum=Rd -> WAIT.
- Cycles with w=0, counted from the WAIT cycle in which s=1: MOV imm 2, MOV reg/MVN 4, CMP 4, ADD/AND 5.
- w returns to 1 in the cycle after the final state.
- s held high continuously back-to-back re-executes IR with exactly one WAIT cycle between instructions.
- load asserted outside WAIT is ignored; IR is stable for the whole instruction.

Test Plan:
- Reset in WAIT: reset_n=0 for 1 edge -> w=1, all strobes 0, sximm8=0000.
- MOV imm: load D1FE, s=1 for 1 cycle -> DECODE, then WIMM with write=1, writenum=1, vsel=0100, sximm8=FFFE; w low exactly 2 cycles.
- ADD: load A148, s -> in order:
  - GETA: loada, readnum=1
  - GETB: loadb, readnum=0
  - CALC: loadc, shift=01, ALUop=00, asel=0
  - WRC: write, writenum=2, vsel=0001
  - w low 5 cycles.
- CMP then MVN:
  - A801 -> loads=1 in the 4th cycle, ALUop=01, write never asserted.
  - B860 -> asel=1, ALUop=11, readnum=0 in GETB, writenum=3 in WRC.
- MOV reg with hazards: load C082 with s=1 and load=1 in the same WAIT cycle -> C082 executes (readnum=2 in GETB, writenum=4 in WRC). load=1 with in=D007 asserted during CALC -> IR stays C082.
- Abort and illegal opcode:
  - reset_n=0 during GETB of A148 -> next cycle WAIT, no write ever occurs.
  - Illegal opcode E000 -> DECODE then WAIT, all strobes 0.
